serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised bit-serial adder/subtractor. It replaces the fixed 8-bit, 1-bit-per-cycle
//  serial adder used in the datapath. Operands are accepted over a valid/ready handshake
//  and processed BITS_PER_CYC bits per clock, LSB first. The result is held on a
//  valid/ready output port together with carry-out and signed overflow.
// PARAMETERS
//  WIDTH         8  operand and result width in bits; must be >= 2
//  BITS_PER_CYC  1  bits processed per ADD cycle; must divide WIDTH (elaboration-time check)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands a, b and sub are valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: A-B; 0: A+B
//  out_valid  out  1      sum, cout and ovf are valid
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out; for subtract, 1 means no borrow (A>=B unsigned)
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  - STEPS = WIDTH/BITS_PER_CYC. The count register is max(1,$clog2(STEPS)) bits wide.
//  - Reset values: state=IDLE; in_ready=1; out_valid=0; sum, cout, ovf, a_reg, b_reg,
//    carry and count all 0.
//  - FSM states are IDLE, ADD and DONE. There are no other states. Any illegal encoding
//    goes to IDLE.
//  - IDLE: in_ready=1. On in_valid at a clock edge:
//      a_reg <= a; b_reg <= sub ? ~b : b; carry <= sub; count <= 0; go to ADD.
//  - ADD: in_ready=0, out_valid=0. Each cycle:
//      - Add the low BITS_PER_CYC bits of a_reg and b_reg with carry (ripple).
//      - Shift a_reg and b_reg right by BITS_PER_CYC.
//      - Shift the slice result into the MSB end of sum (sum >> BITS_PER_CYC).
//      - carry <= slice carry-out; count <= count+1.
//  - ADD exit: on the cycle where count==STEPS-1, go to DONE and register:
//      cout <= slice carry-out
//      ovf  <= slice carry-out XOR (carry into bit WIDTH-1)
//  - DONE: out_valid=1, in_ready=0. sum, cout and ovf hold while out_ready=0. When
//    out_ready=1, go to IDLE. A new operand is not accepted in that same cycle.
//  - Latency: the handshake edge is T0; out_valid rises STEPS cycles later (at T0+STEPS).
//    Throughput is one operation per STEPS+2 cycles when out_ready is held high.
//  - sum changes only in ADD. cout and ovf change only on the ADD->DONE edge. All outputs
//    keep their values through IDLE until the next operation runs.
//  - in_valid or out_ready toggling outside IDLE/DONE has no effect. Operands must be
//    stable only on the accepting edge.
//  - rst asserted in any state aborts the operation immediately and restores reset values.
//    A partial result is never presented.
//  - Arithmetic is modulo 2^WIDTH. The carry chain is exact for every input, including
//    0xFF.. + 0xFF.. and 0 - 0.
// STRUCTURE
//  - Shared package serial_arith_pkg holds:
//      - the state enum (IDLE=0, ADD=1, DONE=2, 2 bits);
//      - the function steps(WIDTH, BITS_PER_CYC).
//  - One sub-module, serial_add_slice #(N=BITS_PER_CYC), is combinational.
//      Inputs: a[N], b[N], cin. Outputs: s[N], cout, c_msb (carry into bit N-1).
//      The top level uses c_msb from the final step for ovf.
//  - The top level holds the FSM, the operand and result shift registers, the count and
//    the carry register.
// TESTING
//  1. WIDTH=8, BPC=1: 0x5A + 0x3C -> sum=0x96, cout=0, ovf=1; out_valid exactly 8 cycles
//     after the accept edge.
//  2. WIDTH=8: 0xFF + 0x01 -> sum=0x00, cout=1, ovf=0. Also 0x7F + 0x01 -> 0x80, cout=0,
//     ovf=1.
//  3. WIDTH=8, sub=1: 0x10 - 0x20 -> 0xF0, cout=0, ovf=0. Also 0x80 - 0x01 -> 0x7F,
//     cout=1, ovf=1.
//  4. WIDTH=16, BPC=4: 0x1234 + 0xEDCC -> 0x0000, cout=1, ovf=0; out_valid after 4 cycles.
//  5. Back-pressure: hold out_ready=0 for 10 cycles -> sum, cout and out_valid stable;
//     in_ready=0; in_valid pulses ignored. Release -> IDLE, then a back-to-back operation
//     gives the correct result.
//  6. Assert rst mid-ADD (count=3) -> all outputs 0 and in_ready=1 asynchronously. The
//     next operation 0x01 + 0x01 -> 0x02.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and helpers for the bit-serial adder/subtractor
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps(input int width, input int bits_per_cyc);
    return width / bits_per_cyc;
  endfunction

endpackage

// File: rtl/serial_add_slice.sv
// rtl/serial_add_slice.sv - combinational N-bit ripple slice with carry into the MSB
module serial_add_slice #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s     = total[N-1:0];
  assign cout  = total[N];
  // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
  assign c_msb = a[N-1] ^ b[N-1] ^ s[N-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, LSB first, valid/ready in and out
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = steps(WIDTH, BITS_PER_CYC);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2 || BITS_PER_CYC < 1 || (WIDTH % BITS_PER_CYC) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYC");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [CW-1:0]     count_q;
  logic              carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;

  logic [BITS_PER_CYC-1:0] slice_s;
  logic                    slice_cout, slice_cmsb;
  logic [WIDTH-1:0]        sum_d;

  serial_add_slice #(.N(BITS_PER_CYC)) u_slice (
    .a     (a_q[BITS_PER_CYC-1:0]),
    .b     (b_q[BITS_PER_CYC-1:0]),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // Each slice result enters at the MSB end so the LSB slice lands at bit 0 after STEPS shifts.
  assign sum_d = (sum_q >> BITS_PER_CYC) | (WIDTH'(slice_s) << (WIDTH - BITS_PER_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end
        end
        ADD: begin
          a_q     <= a_q >> BITS_PER_CYC;
          b_q     <= b_q >> BITS_PER_CYC;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            cout_q      <= slice_cout;
            ovf_q       <= slice_cout ^ slice_cmsb;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed vector bench for serial_addsub (8x1 and 16x4 builds)
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid8 = 1'b0, in_ready8, sub8 = 1'b0, out_valid8, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cout8, ovf8;

  logic        in_valid16 = 1'b0, in_ready16, sub16 = 1'b0, out_valid16, out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cout16, ovf16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYC(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYC(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one operand set, and returns the result plus edges to out_valid.
  task automatic run_op(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, output logic [15:0] s, output logic c,
                        output logic o, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!(wide ? in_ready16 : in_ready8) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (wide) begin
      a16 = av; b16 = bv; sub16 = sv; in_valid16 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; in_valid8 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    lat = 0;
    while (!(wide ? out_valid16 : out_valid8) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = wide ? sum16 : {8'h00, sum8};
    c = wide ? cout16 : cout8;
    o = wide ? ovf16 : ovf8;
  endtask

  initial begin
    logic [15:0] s;
    logic        c, o;
    int          lat;

    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'h64, 8'h1E, 1'b0, 8'h82, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready",   {31'd0, in_ready8},  32'd1);
    chk("rst_out_valid",  {31'd0, out_valid8}, 32'd0);
    chk("rst_sum",        {24'd0, sum8},       32'd0);
    chk("rst_cout_ovf",   {30'd0, cout8, ovf8}, 32'd0);
    chk("rst_in_ready16", {31'd0, in_ready16}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].sub, s, c, o, lat);
      chk($sformatf("v%0d_sum", i),  {16'd0, s},  {24'd0, vecs[i].sum});
      chk($sformatf("v%0d_cout", i), {31'd0, c},  {31'd0, vecs[i].cout});
      chk($sformatf("v%0d_ovf", i),  {31'd0, o},  {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_lat", i),  lat,         32'd8);
    end

    run_op(1'b1, 16'h1234, 16'hEDCC, 1'b0, s, c, o, lat);
    chk("w16_sum",  {16'd0, s}, 32'h0000);
    chk("w16_cout", {31'd0, c}, 32'd1);
    chk("w16_ovf",  {31'd0, o}, 32'd0);
    chk("w16_lat",  lat,        32'd4);
    run_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, s, c, o, lat);
    chk("w16_ovf_sum", {16'd0, s}, 32'h8000);
    chk("w16_ovf_flg", {30'd0, c, o}, 32'b01);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b1, s, c, o, lat);
    chk("w16_sub_sum", {16'd0, s}, 32'hFFFE);
    chk("w16_sub_flg", {30'd0, c, o}, 32'b00);

    // Back-pressure: result must hold and new operands must be ignored.
    out_ready8 = 1'b0;
    run_op(1'b0, 16'h0022, 16'h0011, 1'b0, s, c, o, lat);
    chk("bp_first_sum", {16'd0, s}, 32'h33);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid8 = k[0];
      a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_state", k), {29'd0, out_valid8, in_ready8, cout8}, 32'b100);
      chk($sformatf("bp%0d_sum", k),   {24'd0, sum8}, 32'h33);
    end
    @(negedge clk);
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {30'd0, out_valid8, in_ready8}, 32'b01);
    chk("bp_hold_sum", {24'd0, sum8}, 32'h33);
    run_op(1'b0, 16'h0080, 16'h0080, 1'b0, s, c, o, lat);
    chk("b2b_sum", {16'd0, s},     32'h00);
    chk("b2b_flg", {30'd0, c, o},  32'b11);
    chk("b2b_lat", lat,            32'd8);

    // Reset mid-ADD at count=3: asynchronous clear, then a clean operation.
    @(negedge clk);
    while (!in_ready8) @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_partial_sum", {24'd0, sum8}, 32'h80);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {21'd0, sum8, cout8, ovf8, out_valid8}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, s, c, o, lat);
    chk("post_rst_sum", {16'd0, s},    32'h02);
    chk("post_rst_flg", {30'd0, c, o}, 32'b00);
    chk("post_rst_lat", lat,           32'd8);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
